// File: rtl/serial_request_tx.sv
// serial_request_tx -- UART transmitter for the host link.
//
// Sends REQ_BYTE whenever the OR of the per-console ready levels rises.
// Between those requests it carries arbitrary host bytes through a
// valid/ready handshake. A pending request always wins arbitration in IDLE.
// Framing is 8N1. Defining SERIAL_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit, which gives an 11-bit frame.
//
// Ports:
//   clk, rst       system clock; asynchronous active-high reset
//   request_frame  per-console ready-for-next-frame levels
//   tx_data        host byte to send
//   tx_valid       tx_data is valid
//   tx_ready       host byte accepted on tx_valid && tx_ready
//   tx_uart        serial line, idle high, driven from a register
//   busy           a frame is on the line (START through STOP)
//   req_overrun    one-cycle pulse when a request rise merges into a pending one
module serial_request_tx #(
  parameter int          NUM_CONSOLES = 64,
  parameter int          CLKS_PER_BIT = 25,
  parameter logic [7:0]  REQ_BYTE     = 8'h66
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CONSOLES-1:0] request_frame,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    tx_uart,
  output logic                    busy,
  output logic                    req_overrun
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          pend_q, pend_d;
  logic          any_req_q;
  logic          ovr_q, ovr_d;
`ifdef SERIAL_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       any_req, rise, consume, load_en;
  logic [7:0] load_byte;

  // Request edge detect and coalescing. A rise on the consume cycle
  // re-arms the pending flag without an overrun, because the previous
  // request has just been honoured.
  assign any_req  = |request_frame;
  assign rise     = any_req && !any_req_q;
  assign consume  = (state_q == S_IDLE) && pend_q;
  assign pend_d   = (pend_q && !consume) || rise;
  assign ovr_d    = rise && pend_q && !consume;

  // Depends only on registered state, so tx_valid never loops back into it.
  assign tx_ready    = (state_q == S_IDLE) && !pend_q;
  assign tx_uart     = tx_q;
  assign busy        = (state_q != S_IDLE);
  assign req_overrun = ovr_q;

  // tx_d always carries the line level of the state being entered, so
  // tx_uart and busy change on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    load_en   = 1'b0;
    load_byte = tx_data;
`ifdef SERIAL_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      bit_d = '0;
      tx_d  = 1'b1;
      if (pend_q) begin
        load_en   = 1'b1;
        load_byte = REQ_BYTE;
      end else if (tx_valid) begin
        load_en = 1'b1;
      end
      if (load_en) begin
        state_d = S_START;
        sh_d    = load_byte;
        tx_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = ^load_byte;
`endif
      end
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          tx_d    = sh_q[0];
        end
        S_DATA: begin
          if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
`endif
        S_STOP: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      pend_q    <= 1'b0;
      any_req_q <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      pend_q    <= pend_d;
      any_req_q <= any_req;
      ovr_q     <= ovr_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_request_tx.sv
// Testbench for serial_request_tx. A line decoder samples tx_uart at bit
// centres. Expected bytes and START cycles come from the frame-timing rules:
// START one cycle after accept, a request accepted one cycle after its rise,
// and the next accept no earlier than one frame after the previous START.
module tb_serial_request_tx;

  localparam int CPB = 25;
  localparam int NC  = 64;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FRAME = CPB * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] request_frame = '0;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_uart, busy, req_overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  serial_request_tx #(.NUM_CONSOLES(NC), .CLKS_PER_BIT(CPB), .REQ_BYTE(8'h66)) dut (
    .clk(clk), .rst(rst), .request_frame(request_frame), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_uart(tx_uart), .busy(busy),
    .req_overrun(req_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder and observation counters.
  logic [7:0] rx_byte[$];
  int         rx_start[$];
  int         busy_len[$];
  int         ovr_cnt = 0;
  int         mon_err = 0;
  bit         mon_act = 0;
  int         mon_t, mon_start, mon_k;
  int         busy_run = 0;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    if (rst) begin
      mon_act  = 0;
      busy_run = 0;
    end else begin
      if (req_overrun === 1'b1) ovr_cnt++;
      if (busy === 1'b1) busy_run++;
      else if (busy_run != 0) begin
        busy_len.push_back(busy_run);
        busy_run = 0;
      end
      if (!mon_act) begin
        if (tx_uart === 1'b0) begin
          mon_act = 1; mon_t = 0; mon_start = cyc; mon_byte = '0;
        end
      end else mon_t++;
      if (mon_act && (mon_t % CPB) == CPB / 2) begin
        mon_k = mon_t / CPB;
        if (mon_k == 0) begin
          if (tx_uart !== 1'b0) begin mon_err++; mon_act = 0; end
        end else if (mon_k <= 8) begin
          mon_byte[mon_k-1] = tx_uart;
`ifdef SERIAL_TX_PARITY_EN
        end else if (mon_k == 9) begin
          if (tx_uart !== ^mon_byte) mon_err++;
`endif
        end else begin
          if (tx_uart !== 1'b1) mon_err++;
          rx_byte.push_back(mon_byte);
          rx_start.push_back(mon_start);
          mon_act = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offers a byte and holds it until the handshake; acc = accept cycle.
  task automatic send_byte(input logic [7:0] b, output int acc);
    tx_data  = b;
    tx_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 2000 && acc < 0; n++) begin
      if (tx_ready === 1'b1) acc = cyc;
      tick(1);
    end
    tx_valid = 1'b0;
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout byte=%h never accepted", b);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({tx_uart, busy, tx_ready, req_overrun} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_values got uart/busy/ready/ovr=%b want 1010",
               {tx_uart, busy, tx_ready, req_overrun});
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checks++;
      if ({tx_uart, busy, tx_ready, req_overrun} !== 4'b1010) begin
        failures++;
        $display("FAIL idle_cycle_%0d got uart/busy/ready/ovr=%b want 1010", i,
                 {tx_uart, busy, tx_ready, req_overrun});
      end
    end
  endtask

  task automatic test_single_request;
    int n0 = rx_byte.size();
    int rc;
    request_frame[5] = 1'b1;
    rc = cyc;
    tick(1);
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++; $display("FAIL req_blocks_ready got %b want 0", tx_ready);
    end
    tick(1);
    checks++;
    if ({tx_uart, busy} !== 2'b01) begin
      failures++; $display("FAIL req_start_latency uart/busy=%b want 01 at rise+2", {tx_uart, busy});
    end
    request_frame = '0;
    tick(FRAME - 1);
    checks++;
    if ({busy, tx_ready, tx_uart} !== 3'b101) begin
      failures++; $display("FAIL req_last_stop busy/ready/uart=%b want 101", {busy, tx_ready, tx_uart});
    end
    tick(1);
    checks++;
    if ({busy, tx_ready} !== 2'b01) begin
      failures++; $display("FAIL req_stop_end busy/ready=%b want 01", {busy, tx_ready});
    end
    tick(20);
    checks++;
    if (rx_byte.size() != n0 + 1) begin
      failures++; $display("FAIL req_frame_count got %0d want 1", rx_byte.size() - n0);
    end else begin
      checks++;
      if (rx_byte[n0] !== 8'h66 || rx_start[n0] != rc + 2) begin
        failures++;
        $display("FAIL req_frame got %h@%0d want 66@%0d", rx_byte[n0], rx_start[n0], rc + 2);
      end
    end
  endtask

  task automatic test_host_byte;
    int n0 = rx_byte.size();
    int acc;
    send_byte(8'hA5, acc);
    tick(FRAME + 20);
    checks++;
    if (rx_byte.size() != n0 + 1) begin
      failures++; $display("FAIL host_frame_count got %0d want 1", rx_byte.size() - n0);
    end else begin
      checks++;
      if (rx_byte[n0] !== 8'hA5 || rx_start[n0] != acc + 1) begin
        failures++;
        $display("FAIL host_frame got %h@%0d want a5@%0d", rx_byte[n0], rx_start[n0], acc + 1);
      end
    end
    checks++;
    if (busy_len.size() == 0 || busy_len[$] != FRAME) begin
      failures++;
      $display("FAIL host_busy_len got %0d want %0d",
               (busy_len.size() == 0) ? -1 : busy_len[$], FRAME);
    end
  endtask

  // Request rise and host offer presented on the same cycle while an
  // earlier frame is still on the line, so both compete at the next IDLE.
  task automatic test_contention;
    int n0 = rx_byte.size();
    int a1, a2;
    send_byte(8'h11, a1);
    tick(20);
    request_frame[3] = 1'b1;
    send_byte(8'h3C, a2);
    request_frame = '0;
    checks++;
    if (a2 != a1 + 2 + 2 * FRAME) begin
      failures++; $display("FAIL cont_accept got %0d want %0d", a2, a1 + 2 + 2 * FRAME);
    end
    tick(FRAME + 20);
    checks++;
    if (rx_byte.size() != n0 + 3) begin
      failures++; $display("FAIL cont_count got %0d want 3", rx_byte.size() - n0);
    end else begin
      checks++;
      if (rx_byte[n0+1] !== 8'h66 || rx_start[n0+1] != a1 + 2 + FRAME) begin
        failures++;
        $display("FAIL cont_req_first got %h@%0d want 66@%0d", rx_byte[n0+1], rx_start[n0+1], a1 + 2 + FRAME);
      end
      checks++;
      if (rx_byte[n0+2] !== 8'h3C || rx_start[n0+2] != a1 + 3 + 2 * FRAME) begin
        failures++;
        $display("FAIL cont_host_second got %h@%0d want 3c@%0d", rx_byte[n0+2], rx_start[n0+2], a1 + 3 + 2 * FRAME);
      end
    end
  endtask

  task automatic test_coalesce;
    int n0 = rx_byte.size();
    int o0 = ovr_cnt;
    int acc;
    send_byte(8'hA5, acc);
    tick(30); request_frame[0] = 1'b1;
    tick(30); request_frame[0] = 1'b0;
    tick(30); request_frame[0] = 1'b1;
    tick(30); request_frame[0] = 1'b0;
    tick(3 * FRAME);
    checks++;
    if (ovr_cnt - o0 != 1) begin
      failures++; $display("FAIL coalesce_overrun got %0d pulses want 1", ovr_cnt - o0);
    end
    checks++;
    if (rx_byte.size() != n0 + 2) begin
      failures++; $display("FAIL coalesce_count got %0d want 2", rx_byte.size() - n0);
    end else begin
      checks++;
      if (rx_byte[n0] !== 8'hA5 || rx_byte[n0+1] !== 8'h66 || rx_start[n0+1] != acc + 2 + FRAME) begin
        failures++;
        $display("FAIL coalesce_frames got %h,%h@%0d want a5,66@%0d",
                 rx_byte[n0], rx_byte[n0+1], rx_start[n0+1], acc + 2 + FRAME);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int n0 = rx_byte.size();
    int acc;
    send_byte(8'h00, acc);
    tick(30); request_frame[1] = 1'b1;   // leaves a request pending
    tick(5);  request_frame = '0;
    tick(acc + 1 + 5 * CPB + 10 - cyc);  // middle of data bit 4
    checks++;
    if (tx_uart !== 1'b0) begin
      failures++; $display("FAIL midframe_line got %b want 0", tx_uart);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_uart, busy, tx_ready} !== 3'b101) begin
      failures++; $display("FAIL async_reset uart/busy/ready=%b want 101", {tx_uart, busy, tx_ready});
    end
    tick(3);
    rst = 1'b0;
    tick(2 * FRAME);
    checks++;
    if (rx_byte.size() != n0 || tx_uart !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_quiet frames=%0d uart=%b busy=%b want 0,1,0",
               rx_byte.size() - n0, tx_uart, busy);
    end
  endtask

  task automatic test_random_back_to_back;
    int n0 = rx_byte.size();
    logic [7:0] eb[6];
    int es[6];
    int v, acc, exp_acc, prev_start, g;
    prev_start = 0;
    for (int i = 0; i < 6; i++) begin
      g = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 300));
      tick(g);
      eb[i] = 8'($urandom);
      v = cyc;
      send_byte(eb[i], acc);
      exp_acc = (i == 0 || v >= prev_start + FRAME) ? v : prev_start + FRAME;
      checks++;
      if (acc != exp_acc) begin
        failures++; $display("FAIL rand_accept_%0d got %0d want %0d", i, acc, exp_acc);
      end
      es[i] = exp_acc + 1;
      prev_start = es[i];
    end
    tick(FRAME + 20);
    checks++;
    if (rx_byte.size() != n0 + 6) begin
      failures++; $display("FAIL rand_count got %0d want 6", rx_byte.size() - n0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx_byte[n0+i] !== eb[i] || rx_start[n0+i] != es[i]) begin
          failures++;
          $display("FAIL rand_frame_%0d got %h@%0d want %h@%0d", i, rx_byte[n0+i], rx_start[n0+i], eb[i], es[i]);
        end
      end
    end
  endtask

  initial begin
    tick(3);
    test_reset();
    tick(10);
    test_single_request();
    test_host_byte();
    test_contention();
    test_coalesce();
    test_random_back_to_back();
    test_reset_midframe();
    checks++;
    if (mon_err != 0) begin
      failures++; $display("FAIL line_framing got %0d bad start/parity/stop bits want 0", mon_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
